// File: rtl/cmb_vector_source.sv
// Stimulus generator and response compactor for the 16-in/4-out detector blocks:
// emits one pattern vector per cycle and folds the looped-back response into a MISR.
module cmb_vector_source #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] cfg_count,
    input  logic        stall,
    input  logic        abort,
    input  logic [3:0]  rsp_in,
    output logic [15:0] vec_out,
    output logic        vec_valid,
    output logic [15:0] vec_index,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_ZO    = 2'd3;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] r);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {12'h000, r};
    endfunction

    function automatic logic [15:0] pattern_first(input logic [1:0] m);
        logic [15:0] v;
        case (m)
            MODE_COUNT: v = 16'h0000;
            MODE_LFSR:  v = SEED_EFF;
            MODE_WALK:  v = 16'h0001;
            MODE_ZO:    v = 16'h0000;
            default:    v = 16'h0000;
        endcase
        return v;
    endfunction

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [15:0] count_q;
    logic [15:0] vec_q;
    logic [15:0] idx_q;
    logic [15:0] sig_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] idx_d;
    logic [15:0] vec_d;
    logic        last_s;

    // Next vector of the latched pattern family, derived from the current index/vector.
    always_comb begin
        idx_d  = idx_q + 16'd1;
        last_s = (idx_q == (count_q - 16'd1));
        case (mode_q)
            MODE_COUNT: vec_d = idx_d;
            MODE_LFSR:  vec_d = lfsr_step(vec_q);
            MODE_WALK:  vec_d = 16'h0001 << idx_d[3:0];
            MODE_ZO:    vec_d = idx_d[0] ? 16'hFFFF : 16'h0000;
            default:    vec_d = 16'h0000;
        endcase
    end

    // Run-control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            count_q <= 16'h0000;
            vec_q   <= 16'h0000;
            idx_q   <= 16'h0000;
            sig_q   <= 16'h0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        count_q <= cfg_count;
                        sig_q   <= 16'h0000;
                        if (cfg_count != 16'h0000) begin
                            state_q <= ST_RUN;
                            idx_q   <= 16'h0000;
                            vec_q   <= pattern_first(mode);
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (!stall) begin
                        sig_q <= misr_step(sig_q, rsp_in);
                        // The last vector keeps its value and index visible after the run.
                        if (last_s) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_d;
                            vec_q <= vec_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = valid_q;
    assign vec_index = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_cmb_vector_source.sv
// Directed bench for cmb_vector_source: expected vectors are queued at launch and
// popped as the DUT presents them; the signature is tracked by an independent MISR model.
module tb_cmb_vector_source;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] cfg_count;
    logic        stall;
    logic        abort;
    logic [3:0]  rsp_in;
    logic [15:0] vec_out;
    logic        vec_valid;
    logic [15:0] vec_index;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    logic        rsp_force_en;
    logic [3:0]  rsp_force;

    typedef struct packed {
        logic [15:0] vec;
        logic [15:0] idx;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] sig_m;
    int          check_cnt = 0;
    int          pass_cnt  = 0;

    always #5 clk = ~clk;

    cmb_vector_source #(.LFSR_SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .cfg_count (cfg_count),
        .stall     (stall),
        .abort     (abort),
        .rsp_in    (rsp_in),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_index (vec_index),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    // Stand-in detector: a fixed response or a simple function of the vector.
    function automatic logic [3:0] rsp_of(input logic [15:0] v);
        return v[3:0] ^ v[11:8] ^ {v[15], v[13], v[6], v[1]};
    endfunction

    assign rsp_in = rsp_force_en ? rsp_force : rsp_of(vec_out);

    function automatic logic [3:0] rsp_model(input logic [15:0] v);
        return rsp_force_en ? rsp_force : rsp_of(v);
    endfunction

    function automatic logic [15:0] lfsr_m(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_m(input logic [15:0] s, input logic [3:0] r);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ {12'h000, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input logic [1:0] m, input logic [15:0] n);
        logic [15:0] v;
        exp_t        e;
        v = SEED;
        for (int i = 0; i < int'(n); i++) begin
            case (m)
                2'd0:    e.vec = 16'(i);
                2'd1:    begin e.vec = v; v = lfsr_m(v); end
                2'd2:    e.vec = 16'h0001 << (i % 16);
                default: e.vec = ((i % 2) == 1) ? 16'hFFFF : 16'h0000;
            endcase
            e.idx = 16'(i);
            sb_q.push_back(e);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the launch edge.
    task automatic launch(input logic [1:0] m, input logic [15:0] n);
        mode      = m;
        cfg_count = n;
        start     = 1'b1;
        sig_m     = 16'h0000;
        sb_q.delete();
        push_run(m, n);
        @(negedge clk);
        start     = 1'b0;
        mode      = ~m;
        cfg_count = 16'h0003;
    endtask

    // Compare the presented vector with the queue head; consume it only if not stalled/aborted.
    task automatic sample_and_drive(input logic st, input logic ab);
        stall = st;
        abort = ab;
        if (vec_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("vec_out", {16'h0000, vec_out}, {16'h0000, sb_q[0].vec});
                chk("vec_index", {16'h0000, vec_index}, {16'h0000, sb_q[0].idx});
                if (!st && !ab) begin
                    sig_m = misr_m(sig_m, rsp_model(sb_q[0].vec));
                    void'(sb_q.pop_front());
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        int busy_n;
        n      = 0;
        busy_n = 0;
        while (!done && n < 200) begin
            if (busy) busy_n++;
            sample_and_drive(1'b0, 1'b0);
            n++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_cycles));
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_valid_low"}, {31'd0, vec_valid}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_signature"}, {16'h0000, signature}, {16'h0000, sig_m});
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec_out"}, {16'h0000, vec_out}, 32'd0);
        chk({tag, "_vec_valid"}, {31'd0, vec_valid}, 32'd0);
        chk({tag, "_vec_index"}, {16'h0000, vec_index}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_signature"}, {16'h0000, signature}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        mode         = 2'd0;
        cfg_count    = 16'h0000;
        stall        = 1'b0;
        abort        = 1'b0;
        rsp_force_en = 1'b1;
        rsp_force    = 4'h0;
        sig_m        = 16'h0000;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero/ones, zero response: signature stays 0000.
        launch(2'd3, 16'd2);
        wait_done("zo2", 2);
        chk("zo2_sig_const", {16'h0000, signature}, 32'h0000_0000);

        // Counting pattern with constant response 5, restarted from DONE.
        rsp_force = 4'h5;
        launch(2'd0, 16'd2);
        sample_and_drive(1'b0, 1'b0);
        chk("cnt2_sig_first", {16'h0000, signature}, 32'h0000_0005);
        wait_done("cnt2", 1);
        chk("cnt2_sig_const", {16'h0000, signature}, 32'h0000_000F);

        // LFSR pattern with the vector-dependent response; mode/count changed after launch.
        rsp_force_en = 1'b0;
        launch(2'd1, 16'd2);
        chk("lfsr_v0_const", {16'h0000, vec_out}, 32'h0000_ACE1);
        sample_and_drive(1'b0, 1'b0);
        chk("lfsr_v1_const", {16'h0000, vec_out}, 32'h0000_59C3);
        wait_done("lfsr2", 1);

        // Walking one over 17 vectors; start pulses during RUN must be ignored.
        launch(2'd2, 16'd17);
        start = 1'b1;
        repeat (3) sample_and_drive(1'b0, 1'b0);
        start = 1'b0;
        wait_done("walk17", 14);
        chk("walk17_last_vec", {16'h0000, vec_out}, 32'h0000_0001);
        chk("walk17_last_idx", {16'h0000, vec_index}, 32'd16);

        // Stall three cycles at index 1, then abort at index 2.
        launch(2'd0, 16'd4);
        sample_and_drive(1'b0, 1'b0);
        repeat (3) sample_and_drive(1'b1, 1'b0);
        sample_and_drive(1'b0, 1'b0);
        sample_and_drive(1'b1, 1'b1);
        stall = 1'b0;
        abort = 1'b0;
        chk("abort_valid", {31'd0, vec_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_index", {16'h0000, vec_index}, 32'd2);
        chk("abort_sig", {16'h0000, signature}, {16'h0000, sig_m});
        chk("abort_sig_nonzero", {31'd0, (signature != 16'h0000)}, 32'd1);

        // Zero count from IDLE: straight to DONE, partial signature cleared.
        launch(2'd0, 16'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_valid", {31'd0, vec_valid}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_sig", {16'h0000, signature}, 32'd0);
        @(negedge clk);
        chk("zero_valid_hold", {31'd0, vec_valid}, 32'd0);
        chk("zero_done_hold", {31'd0, done}, 32'd1);

        // Asynchronous reset in the middle of an LFSR run.
        launch(2'd1, 16'd10);
        repeat (3) sample_and_drive(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk_all_zero("postrst");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
